// File: rtl/gshare_bpu_if.sv
// Fetch/execute <-> gshare predictor bus.
// master: pipeline side (fetch requests, execute resolves).
// slave:  predictor side (prediction, history, ready).
interface gshare_bpu_if #(
  parameter int N = 12
) ();
  logic          bpu_ready;
  // fetch lookup
  logic          f_valid;
  logic [31:0]   f_pc;
  logic          f_is_branch;
  logic          f_pred_taken;
  logic [N-1:0]  f_pred_history;
  // execute resolve
  logic          e_resolve_valid;
  logic          e_is_cond_branch;
  logic [31:0]   e_pc;
  logic [N-1:0]  e_pred_history;
  logic          e_taken;
  logic          e_mispredict;

  modport master (
    input  bpu_ready, f_pred_taken, f_pred_history,
    output f_valid, f_pc, f_is_branch,
    output e_resolve_valid, e_is_cond_branch, e_pc, e_pred_history, e_taken, e_mispredict
  );

  modport slave (
    output bpu_ready, f_pred_taken, f_pred_history,
    input  f_valid, f_pc, f_is_branch,
    input  e_resolve_valid, e_is_cond_branch, e_pc, e_pred_history, e_taken, e_mispredict
  );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor: 2^N x 2-bit PHT indexed by pc^ghr, speculative
// GHR with redirect-time repair, one-stage registered PHT update, and a
// post-reset walk that writes every counter to weakly-not-taken.
// Optional: define BPU_STATS_EN to build the lookup/mispredict counters.
module gshare_branch_predictor #(
  parameter int N = 12
) (
  input  logic        clk,
  input  logic        rst,
  gshare_bpu_if.slave bus
`ifdef BPU_STATS_EN
  ,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_mispredicts
`endif
);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] init_idx_q, init_idx_d;
  logic [N-1:0] ghr_q, ghr_d;
  logic         u1_vld_q, u1_vld_d;
  logic [N-1:0] u1_idx_q, u1_idx_d;
  logic         u1_taken_q, u1_taken_d;

  // Counter array has no reset; the INIT walk gives it a known value.
  logic [1:0]   pht_q [0:(1<<N)-1];

  logic         run;
  logic [N-1:0] f_idx;
  logic [1:0]   upd_cur, upd_ctr;

  // Only the word-index bits of the PCs feed the hash.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.f_pc[31:N+2], bus.f_pc[1:0], bus.e_pc[31:N+2], bus.e_pc[1:0]};

  assign run           = (state_q == S_RUN);
  assign bus.bpu_ready = run;

  // Lookup: reads the array as it stands this cycle, so a same-cycle update
  // to the same index is not yet visible.
  assign f_idx              = bus.f_pc[N+1:2] ^ ghr_q;
  assign bus.f_pred_taken   = run & pht_q[f_idx][1] & bus.f_is_branch;
  assign bus.f_pred_history = ghr_q;

  // Saturating read-modify-write of the counter registered last cycle.
  always_comb begin
    upd_cur = pht_q[u1_idx_q];
    upd_ctr = upd_cur;
    if (u1_taken_q) begin
      if (upd_cur != 2'b11) upd_ctr = upd_cur + 2'b01;
    end else begin
      if (upd_cur != 2'b00) upd_ctr = upd_cur - 2'b01;
    end
  end

  // INIT walk / RUN state machine: next state and walk index.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    case (state_q)
      S_INIT: begin
        init_idx_d = init_idx_q + 1'b1;
        if (&init_idx_q) state_d = S_RUN;
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // GHR next value: repair from execute beats the speculative fetch shift.
  always_comb begin
    ghr_d = ghr_q;
    if (run) begin
      if (bus.e_resolve_valid & bus.e_mispredict & bus.e_is_cond_branch)
        ghr_d = {bus.e_pred_history[N-2:0], bus.e_taken};
      else if (bus.e_resolve_valid & bus.e_mispredict)
        ghr_d = bus.e_pred_history;
      else if (bus.f_valid & bus.f_is_branch)
        ghr_d = {ghr_q[N-2:0], bus.f_pred_taken};
    end
  end

  // U1 capture: only conditional branches train the PHT, and only in RUN.
  always_comb begin
    u1_vld_d   = run & bus.e_resolve_valid & bus.e_is_cond_branch;
    u1_idx_d   = bus.e_pc[N+1:2] ^ bus.e_pred_history;
    u1_taken_d = bus.e_taken;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      init_idx_q <= '0;
      ghr_q      <= '0;
      u1_vld_q   <= 1'b0;
      u1_idx_q   <= '0;
      u1_taken_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      ghr_q      <= ghr_d;
      u1_vld_q   <= u1_vld_d;
      u1_idx_q   <= u1_idx_d;
      u1_taken_q <= u1_taken_d;
    end
  end

  // PHT write port: init walk during INIT, trained update during RUN.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT)
      pht_q[init_idx_q] <= 2'b01;
    else if (u1_vld_q)
      pht_q[u1_idx_q] <= upd_ctr;
  end

`ifdef BPU_STATS_EN
  logic [31:0] stat_lookups_q, stat_mispredicts_q;

  // Free-running event counters, wrap at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      if (run & bus.f_valid & bus.f_is_branch)   stat_lookups_q     <= stat_lookups_q + 32'd1;
      if (bus.e_resolve_valid & bus.e_mispredict) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign stat_lookups     = stat_lookups_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Bench for gshare_branch_predictor: directed init/reset/training/repair
// sequences plus random traffic, checked by a scoreboard against a
// counter-array + history-integer reference model.
module tb_gshare_branch_predictor;
  localparam int N  = 12;
  localparam int SZ = 1 << N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gshare_bpu_if #(.N(N)) bus ();

  gshare_branch_predictor #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // scoreboard: {pred_taken, pred_history} expected per RUN cycle
  logic [N:0] exp_q[$];
  bit         sb_on = 1'b0;

  // reference model
  int m_pht[SZ];
  int m_ghr;
  bit p_vld;
  int p_idx;
  bit p_tk;
  int init_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic idle();
    bus.f_valid          = 1'b0;
    bus.f_pc             = '0;
    bus.f_is_branch      = 1'b0;
    bus.e_resolve_valid  = 1'b0;
    bus.e_is_cond_branch = 1'b0;
    bus.e_pc             = '0;
    bus.e_pred_history   = '0;
    bus.e_taken          = 1'b0;
    bus.e_mispredict     = 1'b0;
  endtask

  task automatic model_reset();
    foreach (m_pht[i]) m_pht[i] = 1;
    m_ghr = 0;
    p_vld = 1'b0;
  endtask

  // One RUN cycle: drive, predict from the model, push, clock, advance model.
  // Entered and left at posedge+1.
  task automatic cyc(input bit fv, input logic [31:0] pc, input bit br,
                     input bit rv, input bit cond, input logic [31:0] epc,
                     input logic [N-1:0] eh, input bit tk, input bit mp);
    int idx;
    bit et;
    bus.f_valid = fv; bus.f_pc = pc; bus.f_is_branch = br;
    bus.e_resolve_valid = rv; bus.e_is_cond_branch = cond; bus.e_pc = epc;
    bus.e_pred_history = eh; bus.e_taken = tk; bus.e_mispredict = mp;
    idx = int'((pc >> 2) % SZ) ^ m_ghr;
    et  = br && (m_pht[idx] >= 2);
    exp_q.push_back({et, N'(m_ghr)});
    @(posedge clk);
    // a resolve becomes architectural one cycle after it is seen
    if (p_vld) begin
      if (p_tk) m_pht[p_idx] = (m_pht[p_idx] >= 3) ? 3 : m_pht[p_idx] + 1;
      else      m_pht[p_idx] = (m_pht[p_idx] <= 0) ? 0 : m_pht[p_idx] - 1;
    end
    p_vld = rv && cond;
    p_idx = int'((epc >> 2) % SZ) ^ int'(eh);
    p_tk  = tk;
    if (rv && mp && cond)  m_ghr = ((int'(eh) << 1) | int'(tk)) % SZ;
    else if (rv && mp)     m_ghr = int'(eh);
    else if (fv && br)     m_ghr = ((m_ghr << 1) | int'(et)) % SZ;
    #1;
  endtask

  // Clock through INIT with garbage traffic; counts edges until ready.
  task automatic walk(input int limit, output int edges);
    edges    = 0;
    init_bad = 0;
    while (edges < limit) begin
      @(posedge clk); #1;
      edges++;
      if (bus.bpu_ready) break;
      bus.f_valid          = 1'b1;
      bus.f_is_branch      = 1'b1;
      bus.f_pc             = $urandom;
      bus.e_resolve_valid  = 1'b1;
      bus.e_is_cond_branch = 1'($urandom % 2);
      bus.e_pc             = $urandom;
      bus.e_pred_history   = N'($urandom);
      bus.e_taken          = 1'b1;
      bus.e_mispredict     = 1'($urandom % 2);
      @(negedge clk);
      if (bus.f_pred_taken !== 1'b0)  init_bad++;
      if (bus.f_pred_history !== '0)  init_bad++;
    end
    idle();
  endtask

  // Monitor: one expected entry per cycle the predictor is live.
  always @(negedge clk) begin : mon
    logic [N:0] e;
    if (sb_on && bus.bpu_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_underflow: output with no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("pred_taken",   32'(bus.f_pred_taken),   32'(e[N]));
        chk("pred_history", 32'(bus.f_pred_history), 32'(e[N-1:0]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int edges;
    logic [31:0] pc, epc;
    logic [N-1:0] hs [4];
    hs[0] = 12'h000; hs[1] = 12'h001; hs[2] = 12'h003; hs[3] = 12'h007;

    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.bpu_ready), 0);
    chk("rst_hist",  32'(bus.f_pred_history), 0);
    @(negedge clk) rst = 1'b0;

    // partial walk, then reset mid-INIT
    walk(100, edges);
    chk("partial_not_ready", 32'(bus.bpu_ready), 0);
    rst = 1'b1;
    #1;
    chk("midinit_ready", 32'(bus.bpu_ready), 0);
    @(negedge clk) rst = 1'b0;

    // full walk must restart from entry 0
    walk(5000, edges);
    chk("walk_len",        32'(edges), 32'd4096);
    chk("init_quiet",      32'(init_bad), 0);
    chk("ready_after",     32'(bus.bpu_ready), 1);
    chk("ghr_frozen_init", 32'(bus.f_pred_history), 0);

    model_reset();
    sb_on = 1'b1;

    // training at pc 0x100, hist 0: lookups every cycle without shifting
    repeat (3) cyc(1'b0, 32'h100, 1'b1, 1'b1, 1'b1, 32'h100, '0, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 32'h100, 1'b1, 1'b1, 1'b1, 32'h100, '0, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0,   '0, 1'b0, 1'b0);

    // saturate the four indices a 4-deep taken history walk will hit
    foreach (hs[k]) repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h100, hs[k], 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0);
    repeat (4) cyc(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0);
    chk("ghr_shift4", 32'(bus.f_pred_history), 32'h00F);

    // repair: conditional mispredict beats same-cycle fetch shift; then jump
    cyc(1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 32'h200, 12'h0A5, 1'b1, 1'b1);
    chk("recover_cond", 32'(bus.f_pred_history), 32'h14B);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h300, 12'h3C3, 1'b0, 1'b1);
    chk("recover_jump", 32'(bus.f_pred_history), 32'h3C3);

    // random traffic over a small index neighbourhood so entries collide
    for (int i = 0; i < 3000; i++) begin
      pc  = ($urandom & 32'hFFFF_C000) | (($urandom % 16) << 2);
      epc = ($urandom & 32'hFFFF_C000) | (($urandom % 16) << 2);
      cyc(1'($urandom % 2), pc, 1'($urandom % 2),
          1'($urandom % 2), ($urandom % 4) != 0, epc, N'($urandom % 16),
          1'($urandom % 2), ($urandom % 8) == 0);
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0);
    @(negedge clk);
    sb_on = 1'b0;
    chk("sb_drain", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
